alu_mdu_seq: RTL and testbench
==============================

# alu_mdu_seq

- Multi-cycle multiply/divide sequencer that time-shares the core's single ALU instead of adding a dedicated adder.
- Sits beside the execute stage and receives MUL/DIVU/REMU requests over a valid/ready handshake.
- Runs shift-add multiply or restoring divide. Every 32-bit add or subtract is issued to the ALU through a request/grant port; shifts and compares stay local.
- Returns one 32-bit result per request.

## Interface
- `ITER_W`, default 5: width of the divide iteration counter (32 iterations).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer idle, request is accepted.
- `req_op` in 2: 00 MUL (low word), 01 DIVU, 10 REMU, 11 reserved.
- `req_a` in 32: multiplicand / dividend.
- `req_b` in 32: multiplier / divisor.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_data` out 32: result.
- `busy` out 1: high in any state other than IDLE.
- `alu_req` out 1: sequencer needs the ALU this cycle.
- `alu_gnt` in 1: ALU granted this cycle by the execute-stage mux.
- `alu_a`, `alu_b` out 32: ALU operands.
- `alu_op` out 4: ALU opcode, `ALU_OP_ADD` or `ALU_OP_SUB` only.
- `alu_c` in 32: ALU result, combinational in the same cycle.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset enters IDLE.
- Reset values: `req_ready`=1 (it is `state==IDLE`), all other outputs 0, `alu_op`=`ALU_OP_ADD`.
- Accept: `req_valid & req_ready`. Latch operands, clear `acc`.
- Dispatch on accept:
  - MUL goes to MUL.
  - DIVU/REMU go to DIV. If `req_b`==0, go straight to DONE instead: DIVU result 32'hFFFF_FFFF, REMU result `req_a`.
  - Op 11 goes to DONE with result 0.
- MUL state, each cycle (`mplier` = latched `req_b`, `mcand` = latched `req_a`):
  - If `mplier`==0: go to DONE, result = `acc`.
  - Else if `mplier[0]`: `alu_req`=1, `alu_a`=`acc`, `alu_b`=`mcand`, op ADD. On `alu_gnt`: `acc`<=`alu_c`, `mcand`<<=1, `mplier`>>=1. Without grant: hold, no state change.
  - Else: no ALU request; shift only.
  - The result is the low 32 bits and is correct for signed and unsigned operands. Overflow wraps silently.
- DIV state, 32 iterations with count 31 down to 0:
  - `rs` = {rem, quo[31]}, 33 bits.
  - If `rs` >= divisor (local 33-bit compare): `alu_req`=1, `alu_a`=`rs[31:0]`, `alu_b`=divisor, op SUB. On grant: rem<=`alu_c`, quo<={quo[30:0],1}, count--. The wrap modulo 2^32 is exact because the true difference is < divisor.
  - Else: rem<=`rs[31:0]`, quo<={quo[30:0],0}, count-- with no ALU request.
  - After count 0 is consumed, go to DONE. Result is quo for DIVU, rem for REMU.
- DONE: `rsp_valid`=1, `rsp_data` stable. When `rsp_ready`, go to IDLE.
- When `alu_req`=0, `alu_a`/`alu_b` are 0 and `alu_op` is `ALU_OP_ADD`.
- Reset mid-operation: immediate return to IDLE, partial result discarded, no response.

## Timing
- Accept in cycle T. The first iteration is T+1.
- MUL with full grant: iterations = index of MSB of `req_b` + 1, then 1 zero-check cycle. DONE follows.
  - `req_b`=0 gives `rsp_valid` at T+2.
- DIV with full grant: `rsp_valid` at T+33. Divide by zero gives `rsp_valid` at T+1.
- Each cycle `alu_req` is high without `alu_gnt` adds exactly one cycle.
- `alu_req` is a function of registered state only; it never depends on `alu_gnt`.
- `req_ready` and `rsp_valid` are never both high. A request arriving during DONE waits.
- `rsp_valid` stays high until `rsp_ready`, and `rsp_data` is unchanged while it waits.

## Configuration
- `MDU_DIV_EN` defined: DIV state, divide datapath and divide-by-zero handling are built.
- `MDU_DIV_EN` undefined: no DIV logic. DIVU/REMU go directly to DONE with result 0, with the same latency as op 11. MUL is unaffected.

## Structure
- `defines.vh` (shared): `MDU_OP_MUL`/`MDU_OP_DIVU`/`MDU_OP_REMU` encodings and state encodings. It already holds the `ALU_OP_*` codes, which are reused.
- Sub-module `mdu_div_step`: 33-bit compare, shift, and next-rem/quo selection. It is instantiated only under `MDU_DIV_EN`.

## Test plan
- MUL a=7, b=6, `alu_gnt` tied high → `alu_req` pulses in 2 cycles, `rsp_data`=42, `rsp_valid` at T+5.
- MUL a=32'hFFFF_FFFF, b=32'hFFFF_FFFF → `rsp_data`=1, rsp at T+34. MUL b=0 → `rsp_data`=0 at T+2.
- DIVU 100/7 → 14. REMU 100/7 → 2. Both at T+33. DIVU 32'hFFFF_FFFF/1 → 32'hFFFF_FFFF.
- DIVU 5/0 → 32'hFFFF_FFFF. REMU 5/0 → 5. Both at T+1.
- MUL 7×6 with `alu_gnt` low for 3 cycles at the first request → same result, response 3 cycles later, state held during the stall.
- Assert `rst_n` low mid-DIV → `busy`=0, `req_ready`=1, `rsp_valid`=0 immediately. The next MUL 3×3 returns 9. Hold `rsp_ready` low 4 cycles → `rsp_valid`/`rsp_data` stay stable.

Source files
------------

// File: rtl/alu_mdu_seq_pkg.sv
// Shared encodings and payload types for the ALU-sharing multiply/divide sequencer.
package alu_mdu_seq_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] ALU_OP_ADD = 4'd0;
    localparam logic [3:0] ALU_OP_SUB = 4'd1;

    localparam logic [1:0] MDU_OP_MUL  = 2'b00;
    localparam logic [1:0] MDU_OP_DIVU = 2'b01;
    localparam logic [1:0] MDU_OP_REMU = 2'b10;
    localparam logic [1:0] MDU_OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } mdu_req_t;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration: 33-bit compare, shift and next rem/quo select.
// Only built with MDU_DIV_EN defined.
`ifdef MDU_DIV_EN
module mdu_div_step
    import alu_mdu_seq_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    input  logic [XLEN-1:0] alu_c,
    output logic            ge_c,
    output logic [XLEN-1:0] rs_low_c,
    output logic [XLEN-1:0] rem_nxt_c,
    output logic [XLEN-1:0] quo_nxt_c
);

    logic [XLEN:0] rs;

    // Shift the next dividend bit into the partial remainder and compare locally.
    always_comb begin
        rs        = {rem, quo[XLEN-1]};
        ge_c      = (rs >= {1'b0, divisor});
        rs_low_c  = rs[XLEN-1:0];
        rem_nxt_c = ge_c ? alu_c : rs[XLEN-1:0];
        quo_nxt_c = {quo[XLEN-2:0], ge_c};
    end

endmodule
`endif

// File: rtl/alu_mdu_seq.sv
// Multi-cycle MUL/DIVU/REMU sequencer borrowing the core ALU for every add/subtract.
// Define MDU_DIV_EN to build the divide path; otherwise DIVU/REMU return 0.
module alu_mdu_seq
    import alu_mdu_seq_pkg::*;
#(
    parameter int unsigned ITER_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            busy,
    output logic            alu_req,
    input  logic            alu_gnt,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_c
);

    state_e            state, state_nxt;
    logic [XLEN-1:0]   acc, acc_nxt;     // MUL accumulator / DIV remainder
    logic [XLEN-1:0]   opa, opa_nxt;     // MUL multiplicand / DIV quotient
    logic [XLEN-1:0]   opb, opb_nxt;     // MUL multiplier / DIV divisor
    logic [XLEN-1:0]   res, res_nxt;
    logic [1:0]        op, op_nxt;
    logic [ITER_W-1:0] cnt, cnt_nxt;
    mdu_req_t          req_in;

    assign req_in = '{op: req_op, a: req_a, b: req_b};

`ifdef MDU_DIV_EN
    logic            div_ge;
    logic [XLEN-1:0] div_rs_low;
    logic [XLEN-1:0] div_rem_nxt;
    logic [XLEN-1:0] div_quo_nxt;

    mdu_div_step u_div_step (
        .rem       (acc),
        .quo       (opa),
        .divisor   (opb),
        .alu_c     (alu_c),
        .ge_c      (div_ge),
        .rs_low_c  (div_rs_low),
        .rem_nxt_c (div_rem_nxt),
        .quo_nxt_c (div_quo_nxt)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            op    <= MDU_OP_MUL;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            opa   <= opa_nxt;
            opb   <= opb_nxt;
            res   <= res_nxt;
            op    <= op_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, datapath update and ALU port drive.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        opa_nxt   = opa;
        opb_nxt   = opb;
        res_nxt   = res;
        op_nxt    = op;
        cnt_nxt   = cnt;
        alu_req   = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = ALU_OP_ADD;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    op_nxt  = req_in.op;
                    acc_nxt = '0;
                    opa_nxt = req_in.a;
                    opb_nxt = req_in.b;
                    cnt_nxt = {ITER_W{1'b1}};
                    case (req_in.op)
                        MDU_OP_MUL: state_nxt = ST_MUL;
`ifdef MDU_DIV_EN
                        MDU_OP_DIVU, MDU_OP_REMU: begin
                            if (req_in.b == '0) begin
                                state_nxt = ST_DONE;
                                res_nxt   = (req_in.op == MDU_OP_DIVU) ? '1 : req_in.a;
                            end else begin
                                state_nxt = ST_DIV;
                            end
                        end
`endif
                        default: begin
                            state_nxt = ST_DONE;
                            res_nxt   = '0;
                        end
                    endcase
                end
            end

            ST_MUL: begin
                if (opb == '0) begin
                    state_nxt = ST_DONE;
                    res_nxt   = acc;
                end else if (opb[0]) begin
                    alu_req = 1'b1;
                    alu_a   = acc;
                    alu_b   = opa;
                    if (alu_gnt) begin
                        acc_nxt = alu_c;
                        opa_nxt = {opa[XLEN-2:0], 1'b0};
                        opb_nxt = {1'b0, opb[XLEN-1:1]};
                    end
                end else begin
                    opa_nxt = {opa[XLEN-2:0], 1'b0};
                    opb_nxt = {1'b0, opb[XLEN-1:1]};
                end
            end

`ifdef MDU_DIV_EN
            ST_DIV: begin
                if (div_ge) begin
                    alu_req = 1'b1;
                    alu_a   = div_rs_low;
                    alu_b   = opb;
                    alu_op  = ALU_OP_SUB;
                end
                // Subtract iterations stall until granted; restore iterations never wait.
                if (!div_ge || alu_gnt) begin
                    acc_nxt = div_rem_nxt;
                    opa_nxt = div_quo_nxt;
                    cnt_nxt = cnt - ITER_W'(1);
                    if (cnt == '0) begin
                        state_nxt = ST_DONE;
                        res_nxt   = (op == MDU_OP_DIVU) ? div_quo_nxt : div_rem_nxt;
                    end
                end
            end
`endif

            ST_DONE: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_DONE);
    assign rsp_data  = res;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed scoreboard bench for alu_mdu_seq with a behavioural ALU on the shared port.
module tb_alu_mdu_seq;
    import alu_mdu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        busy;
    logic        alu_req;
    logic        alu_gnt = 1'b1;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_c;

    int total = 0;
    int bad = 0;
    int stall_left = 0;
    int req_cycles = 0;
    int gnt_cycles = 0;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;
    exp_t sb[$];

    alu_mdu_seq #(.ITER_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .alu_req   (alu_req),
        .alu_gnt   (alu_gnt),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_c     (alu_c)
    );

    always #5 clk = ~clk;

    assign alu_c = (alu_op == ALU_OP_SUB) ? (alu_a - alu_b) : (alu_a + alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        case (op)
            2'b00: r = a * b;
`ifdef MDU_DIV_EN
            2'b01: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10: r = (b == 0) ? a : a % b;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] b);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        if (op == 2'b00) return n + 2;
`ifdef MDU_DIV_EN
        if (op != 2'b11) return (b == 0) ? 1 : 33;
`endif
        return 1;
    endfunction

    // Grant control, ALU-port activity counters and per-cycle invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            if (alu_req && stall_left > 0) begin
                alu_gnt = 1'b0;
                stall_left--;
            end else begin
                alu_gnt = 1'b1;
            end
            if (alu_req) req_cycles++;
            if (alu_req && alu_gnt) gnt_cycles++;
            chk("ready_valid_excl", 32'(req_ready & rsp_valid), 32'd0);
            if (!alu_req) begin
                chk("idle_alu_a", alu_a, 32'd0);
                chk("idle_alu_b", alu_b, 32'd0);
                chk("idle_alu_op", 32'(alu_op), 32'(ALU_OP_ADD));
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk("req_ready_before_send", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int extra, input int hold);
        exp_t e;
        int   n;
        req_cycles = 0;
        gnt_cycles = 0;
        sb.push_back('{data: model(op, a, b), lat: model_lat(op, b) + extra});
        send(op, a, b);
        n = 1;
        @(negedge clk);
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
        e = sb.pop_front();
        chk({tag, "_data"}, rsp_data, e.data);
        chk({tag, "_latency"}, 32'(n), 32'(e.lat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_data"}, rsp_data, e.data);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_back_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_req", 32'(alu_req), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'(ALU_OP_ADD));
        @(negedge clk);
        rst_n = 1'b1;

        run("mul_7x6", 2'b00, 32'd7, 32'd6, 0, 0);
        chk("mul_7x6_alu_reqs", 32'(req_cycles), 32'd2);
        run("mul_ffxff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run("mul_b0", 2'b00, 32'h1234_5678, 32'd0, 0, 0);
        run("mul_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 0, 1);
        run("divu_100_7", 2'b01, 32'd100, 32'd7, 0, 0);
        run("remu_100_7", 2'b10, 32'd100, 32'd7, 0, 0);
        run("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 0, 0);
        run("divu_5_0", 2'b01, 32'd5, 32'd0, 0, 0);
        run("remu_5_0", 2'b10, 32'd5, 32'd0, 0, 0);
        run("op_rsvd", 2'b11, 32'd9, 32'd3, 0, 0);

        stall_left = 3;
        run("mul_7x6_stall", 2'b00, 32'd7, 32'd6, 3, 0);
        chk("stall_alu_reqs", 32'(req_cycles), 32'd5);
        chk("stall_alu_gnts", 32'(gnt_cycles), 32'd2);

        // Abort a long operation with reset; nothing may come back from it.
`ifdef MDU_DIV_EN
        send(2'b01, 32'd1000, 32'd3);
`else
        send(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`endif
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        stall_left = 0;
        @(negedge clk);
        rst_n = 1'b1;

        run("mul_3x3_hold", 2'b00, 32'd3, 32'd3, 0, 4);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
